// File: rtl/fft_pkg.sv
// fft_pkg: shared constants and FSM encoding for the
// radix-2 FFT stage sequencer.
package fft_pkg;

  localparam int FFT_N  = 16;
  localparam int STAGES = $clog2(FFT_N);
  localparam int HALF   = FFT_N / 2;
  localparam int SW     = $clog2(FFT_N / 4);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ARM   = 3'd1,
    ISSUE = 3'd2,
    DRAIN = 3'd3,
    NEXT  = 3'd4,
    DONE  = 3'd5
  } state_e;

endpackage

// File: rtl/stage_counter.sv
// stage_counter: clearable up-counter that saturates at MAX
// and flags the terminal value.
module stage_counter #(
  parameter int W   = 3,
  parameter int MAX = 7
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr_i,
  input  logic         en_i,
  output logic [W-1:0] cnt_o,
  output logic         tc_o
);

  logic [W-1:0] cnt_q;

  assign cnt_o = cnt_q;
  assign tc_o  = (cnt_q == W'(MAX));

  // count while enabled, hold at MAX, clear wins
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (en_i && !tc_o) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/fft_stage_sched.sv
// fft_stage_sched: runs all log2(N) stages of one FFT,
// arming the twiddle mapper and issuing butterflies.
module fft_stage_sched
  import fft_pkg::*;
#(
  parameter int N          = FFT_N,
  parameter int BFLY_LAT   = 3,
  parameter int TW_TIMEOUT = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   fft_start,
  output logic                   fft_busy,
  output logic                   fft_done,
  output logic                   tw_start,
  output logic [$clog2(N/4)-1:0] tw_stage,
  input  logic                   tw_we,
  output logic                   bfly_valid,
  output logic [$clog2(N/2)-1:0] bfly_idx,
  output logic                   rd_bank,
  output logic                   wr_bank,
  output logic                   result_bank,
  output logic                   tw_timeout
);

  localparam int NSTG = $clog2(N);
  localparam int HN   = N / 2;
  localparam int STW  = $clog2(NSTG);
  localparam int TSW  = $clog2(N / 4);
  localparam int IW   = $clog2(HN);
  localparam int DW   = $clog2(BFLY_LAT + 1);
  localparam int WW   = $clog2(TW_TIMEOUT + 1);

  state_e          state_q;
  logic [STW-1:0]  stage_q;
  logic            rd_bank_q;
  logic            busy_q;
  logic            done_q;
  logic            tw_start_q;
  logic            bfly_valid_q;
  logic            result_q;
  logic            timeout_q;

  logic [IW-1:0]   issue_cnt;
  logic            issue_tc;
  logic [DW-1:0]   drain_cnt;
  logic            drain_tc;
  logic [WW-1:0]   wait_cnt;
  logic            wait_tc;
  logic            unused_cnt;

  stage_counter #(
    .W   (IW),
    .MAX (HN - 1)
  ) u_issue (
    .clk   (clk),
    .rst_n (rst_n),
    .clr_i ((state_q != ISSUE) || issue_tc),
    .en_i  (state_q == ISSUE),
    .cnt_o (issue_cnt),
    .tc_o  (issue_tc)
  );

  stage_counter #(
    .W   (DW),
    .MAX (BFLY_LAT - 1)
  ) u_drain (
    .clk   (clk),
    .rst_n (rst_n),
    .clr_i (state_q != DRAIN),
    .en_i  (state_q == DRAIN),
    .cnt_o (drain_cnt),
    .tc_o  (drain_tc)
  );

  stage_counter #(
    .W   (WW),
    .MAX (TW_TIMEOUT - 1)
  ) u_wait (
    .clk   (clk),
    .rst_n (rst_n),
    .clr_i (state_q != ARM),
    .en_i  (state_q == ARM),
    .cnt_o (wait_cnt),
    .tc_o  (wait_tc)
  );

  assign unused_cnt  = ^{wait_cnt, drain_cnt};

  assign fft_busy    = busy_q;
  assign fft_done    = done_q;
  assign tw_start    = tw_start_q;
  assign tw_stage    = TSW'(stage_q);
  assign bfly_valid  = bfly_valid_q;
  assign bfly_idx    = issue_cnt;
  assign rd_bank     = rd_bank_q;
  assign wr_bank     = ~rd_bank_q;
  assign result_bank = result_q;
  assign tw_timeout  = timeout_q;

  // stage sequencing FSM with registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      stage_q      <= '0;
      rd_bank_q    <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      tw_start_q   <= 1'b0;
      bfly_valid_q <= 1'b0;
      result_q     <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (fft_start) begin
            state_q    <= ARM;
            stage_q    <= '0;
            rd_bank_q  <= 1'b0;
            timeout_q  <= 1'b0;
            busy_q     <= 1'b1;
            tw_start_q <= 1'b1;
          end
        end
        ARM: begin
          if (tw_we) begin
            state_q      <= ISSUE;
            tw_start_q   <= 1'b0;
            bfly_valid_q <= 1'b1;
          end else if (wait_tc) begin
            state_q    <= IDLE;
            tw_start_q <= 1'b0;
            timeout_q  <= 1'b1;
            busy_q     <= 1'b0;
          end
        end
        ISSUE: begin
          if (issue_tc) begin
            state_q      <= DRAIN;
            bfly_valid_q <= 1'b0;
          end
        end
        DRAIN: begin
          if (drain_tc) begin
            state_q <= NEXT;
          end
        end
        NEXT: begin
          if (stage_q == STW'(NSTG - 1)) begin
            state_q  <= DONE;
            done_q   <= 1'b1;
            busy_q   <= 1'b0;
            result_q <= ~rd_bank_q;
          end else begin
            state_q    <= ARM;
            stage_q    <= stage_q + 1'b1;
            rd_bank_q  <= ~rd_bank_q;
            tw_start_q <= 1'b1;
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fft_stage_sched.sv
// tb_fft_stage_sched: self-checking bench with a mapper
// model and a schedule-based reference of one transform.
module tb_fft_stage_sched;

  localparam int N    = 16;
  localparam int LAT  = 3;
  localparam int TMO  = 4;
  localparam int NST  = 4;
  localparam int HALF = 8;
  localparam int MAXC = 80;

  logic       clk;
  logic       rst_n;
  logic       fft_start;
  logic       fft_busy;
  logic       fft_done;
  logic       tw_start;
  logic [1:0] tw_stage;
  logic       tw_we;
  logic       bfly_valid;
  logic [2:0] bfly_idx;
  logic       rd_bank;
  logic       wr_bank;
  logic       result_bank;
  logic       tw_timeout;

  int checks = 0;
  int errors = 0;
  int map_dly[NST];
  int mk;
  int e_total;

  logic       c_ts[MAXC];
  logic [1:0] c_stg[MAXC];
  logic       c_bv[MAXC];
  logic [2:0] c_idx[MAXC];
  logic       c_rd[MAXC];
  logic       c_wr[MAXC];
  logic       c_busy[MAXC];
  logic       c_done[MAXC];
  logic       c_res[MAXC];
  logic       c_tmo[MAXC];

  logic       e_ts[MAXC];
  logic [1:0] e_stg[MAXC];
  logic       e_bv[MAXC];
  logic [2:0] e_idx[MAXC];
  logic       e_rd[MAXC];
  logic       e_busy[MAXC];
  logic       e_done[MAXC];

  fft_stage_sched #(
    .N          (N),
    .BFLY_LAT   (LAT),
    .TW_TIMEOUT (TMO)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .fft_start   (fft_start),
    .fft_busy    (fft_busy),
    .fft_done    (fft_done),
    .tw_start    (tw_start),
    .tw_stage    (tw_stage),
    .tw_we       (tw_we),
    .bfly_valid  (bfly_valid),
    .bfly_idx    (bfly_idx),
    .rd_bank     (rd_bank),
    .wr_bank     (wr_bank),
    .result_bank (result_bank),
    .tw_timeout  (tw_timeout)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // mapper model: tw_we is high at the edge that is
  // map_dly[stage] cycles after tw_start rose; 0 = never
  initial begin
    mk    = 0;
    tw_we = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (tw_start === 1'b1) begin
        mk++;
        tw_we = (map_dly[int'(tw_stage)] != 0) &&
                (mk == map_dly[int'(tw_stage)]);
      end else begin
        mk    = 0;
        tw_we = 1'b0;
      end
    end
  end

  // expected per-cycle schedule; cycle 0 = accepting edge
  task automatic build_model();
    int t;
    t = 0;
    for (int k = 0; k < MAXC; k++) begin
      e_ts[k]   = 1'b0;
      e_stg[k]  = 2'd0;
      e_bv[k]   = 1'b0;
      e_idx[k]  = 3'd0;
      e_rd[k]   = 1'b0;
      e_busy[k] = 1'b0;
      e_done[k] = 1'b0;
    end
    for (int s = 0; s < NST; s++) begin
      for (int j = 0; j < map_dly[s]; j++) begin
        e_ts[t]   = 1'b1;
        e_stg[t]  = 2'(s);
        e_rd[t]   = 1'(s % 2);
        e_busy[t] = 1'b1;
        t++;
      end
      for (int i = 0; i < HALF; i++) begin
        e_bv[t]   = 1'b1;
        e_idx[t]  = 3'(i);
        e_rd[t]   = 1'(s % 2);
        e_busy[t] = 1'b1;
        t++;
      end
      for (int j = 0; j < LAT + 1; j++) begin
        e_rd[t]   = 1'(s % 2);
        e_busy[t] = 1'b1;
        t++;
      end
    end
    e_total   = t;
    e_done[t] = 1'b1;
    for (int k = t; k < MAXC; k++) e_rd[k] = 1'((NST - 1) % 2);
  endtask

  // pulse fft_start, then sample ncyc cycles; extra start
  // pulses are applied at the edge after sample sa / sb
  task automatic capture(input int ncyc, input int sa,
                         input int sb);
    @(posedge clk);
    #1;
    fft_start = 1'b1;
    for (int k = 0; k < ncyc; k++) begin
      @(posedge clk);
      #1;
      c_ts[k]   = tw_start;
      c_stg[k]  = tw_stage;
      c_bv[k]   = bfly_valid;
      c_idx[k]  = bfly_idx;
      c_rd[k]   = rd_bank;
      c_wr[k]   = wr_bank;
      c_busy[k] = fft_busy;
      c_done[k] = fft_done;
      c_res[k]  = result_bank;
      c_tmo[k]  = tw_timeout;
      fft_start = (k == sa) || (k == sb);
    end
    fft_start = 1'b0;
  endtask

  task automatic test_reset();
    #3;
    checks++;
    if ({fft_busy, fft_done, tw_start, bfly_valid} !== 4'b0) begin
      errors++;
      $display("FAIL rst_ctl got %b want 0000",
               {fft_busy, fft_done, tw_start, bfly_valid});
    end
    checks++;
    if ({tw_stage, bfly_idx} !== 5'b0) begin
      errors++;
      $display("FAIL rst_idx got %b want 0", {tw_stage, bfly_idx});
    end
    checks++;
    if ({rd_bank, wr_bank, result_bank, tw_timeout} !== 4'b0100) begin
      errors++;
      $display("FAIL rst_bank got %b want 0100",
               {rd_bank, wr_bank, result_bank, tw_timeout});
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
  endtask

  task automatic test_nominal();
    int fd;
    int np;
    for (int s = 0; s < NST; s++) map_dly[s] = 1;
    build_model();
    capture(60, -1, -1);
    fd = -1;
    np = 0;
    for (int k = 0; k < 60; k++) begin
      checks++;
      if (c_ts[k] !== e_ts[k]) begin
        errors++;
        $display("FAIL nom_tw_start k=%0d got %b want %b",
                 k, c_ts[k], e_ts[k]);
      end
      if (e_ts[k]) begin
        checks++;
        if (c_stg[k] !== e_stg[k]) begin
          errors++;
          $display("FAIL nom_tw_stage k=%0d got %0d want %0d",
                   k, c_stg[k], e_stg[k]);
        end
      end
      checks++;
      if (c_bv[k] !== e_bv[k]) begin
        errors++;
        $display("FAIL nom_bfly_valid k=%0d got %b want %b",
                 k, c_bv[k], e_bv[k]);
      end
      if (e_bv[k]) begin
        checks++;
        if (c_idx[k] !== e_idx[k]) begin
          errors++;
          $display("FAIL nom_bfly_idx k=%0d got %0d want %0d",
                   k, c_idx[k], e_idx[k]);
        end
      end
      checks++;
      if ({c_busy[k], c_done[k]} !== {e_busy[k], e_done[k]}) begin
        errors++;
        $display("FAIL nom_busy_done k=%0d got %b%b want %b%b",
                 k, c_busy[k], c_done[k], e_busy[k], e_done[k]);
      end
      if (c_ts[k] === 1'b1 && (k == 0 || c_ts[k-1] !== 1'b1)) np++;
      if (fd < 0 && c_done[k] === 1'b1) fd = k;
    end
    checks++;
    if (fd != 52) begin
      errors++;
      $display("FAIL nom_done_cycle got %0d want 52", fd);
    end
    checks++;
    if (np != NST) begin
      errors++;
      $display("FAIL nom_tw_pulses got %0d want %0d", np, NST);
    end
    checks++;
    if (c_res[52] !== 1'b0) begin
      errors++;
      $display("FAIL nom_result_bank got %b want 0", c_res[52]);
    end
  endtask

  task automatic test_banks();
    int si;
    for (int s = 0; s < NST; s++) map_dly[s] = $urandom_range(1, 3);
    build_model();
    capture(e_total + 4, -1, -1);
    si = 0;
    for (int k = 0; k < e_total + 4; k++) begin
      checks++;
      if (c_rd[k] !== e_rd[k] || c_wr[k] !== ~e_rd[k]) begin
        errors++;
        $display("FAIL bank_rd_wr k=%0d got %b%b want %b%b",
                 k, c_rd[k], c_wr[k], e_rd[k], ~e_rd[k]);
      end
      if (c_bv[k] === 1'b1 && (k == 0 || c_bv[k-1] !== 1'b1)) begin
        checks++;
        if (c_rd[k] !== 1'(si % 2)) begin
          errors++;
          $display("FAIL bank_stage_rd stage=%0d got %b want %b",
                   si, c_rd[k], 1'(si % 2));
        end
        si++;
      end
    end
    checks++;
    if (si != NST) begin
      errors++;
      $display("FAIL bank_stage_count got %0d want %0d", si, NST);
    end
  endtask

  task automatic test_random_mapper();
    int fd;
    for (int it = 0; it < 4; it++) begin
      for (int s = 0; s < NST; s++) map_dly[s] = $urandom_range(1, 3);
      build_model();
      capture(e_total + 4, -1, -1);
      fd = -1;
      for (int k = 0; k < e_total + 4; k++) begin
        checks++;
        if ({c_ts[k], c_bv[k], c_busy[k], c_done[k]} !==
            {e_ts[k], e_bv[k], e_busy[k], e_done[k]}) begin
          errors++;
          $display("FAIL rnd_ctl it=%0d k=%0d got %b want %b", it, k,
                   {c_ts[k], c_bv[k], c_busy[k], c_done[k]},
                   {e_ts[k], e_bv[k], e_busy[k], e_done[k]});
        end
        if (e_bv[k]) begin
          checks++;
          if (c_idx[k] !== e_idx[k]) begin
            errors++;
            $display("FAIL rnd_idx it=%0d k=%0d got %0d want %0d",
                     it, k, c_idx[k], e_idx[k]);
          end
        end
        if (fd < 0 && c_done[k] === 1'b1) fd = k;
      end
      checks++;
      if (fd != e_total) begin
        errors++;
        $display("FAIL rnd_done_cycle it=%0d got %0d want %0d",
                 it, fd, e_total);
      end
    end
  endtask

  task automatic test_slow_mapper();
    int fd;
    for (int s = 0; s < NST; s++) map_dly[s] = 3;
    build_model();
    capture(64, -1, -1);
    fd = -1;
    for (int k = 0; k < 64; k++) begin
      checks++;
      if ({c_ts[k], c_bv[k]} !== {e_ts[k], e_bv[k]}) begin
        errors++;
        $display("FAIL slow_ts_bv k=%0d got %b want %b",
                 k, {c_ts[k], c_bv[k]}, {e_ts[k], e_bv[k]});
      end
      if (fd < 0 && c_done[k] === 1'b1) fd = k;
    end
    checks++;
    if (fd != 60) begin
      errors++;
      $display("FAIL slow_done_cycle got %0d want 60", fd);
    end
  endtask

  task automatic test_timeout();
    int fd;
    for (int s = 0; s < NST; s++) map_dly[s] = 0;
    capture(12, -1, -1);
    for (int k = 0; k < 12; k++) begin
      checks++;
      if ({c_ts[k], c_busy[k], c_tmo[k]} !==
          {k < TMO, k < TMO, k >= TMO}) begin
        errors++;
        $display("FAIL tmo_flags k=%0d got %b want %b", k,
                 {c_ts[k], c_busy[k], c_tmo[k]},
                 {k < TMO, k < TMO, k >= TMO});
      end
      checks++;
      if ({c_bv[k], c_done[k]} !== 2'b00) begin
        errors++;
        $display("FAIL tmo_no_issue k=%0d got %b want 00",
                 k, {c_bv[k], c_done[k]});
      end
    end
    for (int s = 0; s < NST; s++) map_dly[s] = 1;
    build_model();
    capture(56, -1, -1);
    checks++;
    if (c_tmo[0] !== 1'b0) begin
      errors++;
      $display("FAIL tmo_cleared got %b want 0", c_tmo[0]);
    end
    fd = -1;
    for (int k = 0; k < 56; k++)
      if (fd < 0 && c_done[k] === 1'b1) fd = k;
    checks++;
    if (fd != 52) begin
      errors++;
      $display("FAIL tmo_rerun_done got %0d want 52", fd);
    end
  endtask

  task automatic test_start_busy();
    int nd;
    for (int s = 0; s < NST; s++) map_dly[s] = 1;
    build_model();
    capture(60, 5, 30);
    nd = 0;
    for (int k = 0; k < 60; k++) begin
      checks++;
      if ({c_ts[k], c_done[k]} !== {e_ts[k], e_done[k]}) begin
        errors++;
        $display("FAIL busy_ts_done k=%0d got %b want %b",
                 k, {c_ts[k], c_done[k]}, {e_ts[k], e_done[k]});
      end
      if (e_ts[k]) begin
        checks++;
        if (c_stg[k] !== e_stg[k]) begin
          errors++;
          $display("FAIL busy_stage k=%0d got %0d want %0d",
                   k, c_stg[k], e_stg[k]);
        end
      end
      if (c_done[k] === 1'b1) nd++;
    end
    checks++;
    if (nd != 1) begin
      errors++;
      $display("FAIL busy_done_count got %0d want 1", nd);
    end
    capture(60, 52, -1);
    for (int k = 53; k < 60; k++) begin
      checks++;
      if ({c_busy[k], c_ts[k]} !== 2'b00) begin
        errors++;
        $display("FAIL start_in_done k=%0d got %b want 00",
                 k, {c_busy[k], c_ts[k]});
      end
    end
  endtask

  task automatic test_reset_mid_run();
    int fd;
    int nd;
    for (int s = 0; s < NST; s++) map_dly[s] = 1;
    build_model();
    capture(30, -1, -1);
    checks++;
    if ({c_bv[29], c_idx[29]} !== {e_bv[29], e_idx[29]}) begin
      errors++;
      $display("FAIL mid_pre_issue got %b want %b",
               {c_bv[29], c_idx[29]}, {e_bv[29], e_idx[29]});
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({fft_busy, fft_done, tw_start, bfly_valid, bfly_idx,
         tw_stage, rd_bank, wr_bank, result_bank, tw_timeout}
        !== 13'b0000_000_00_0100) begin
      errors++;
      $display("FAIL mid_async_rst got %b want 0000000000100",
               {fft_busy, fft_done, tw_start, bfly_valid, bfly_idx,
                tw_stage, rd_bank, wr_bank, result_bank, tw_timeout});
    end
    nd = 0;
    repeat (3) begin
      @(posedge clk);
      #1;
      if (fft_done === 1'b1) nd++;
    end
    @(negedge clk);
    rst_n = 1'b1;
    checks++;
    if (nd != 0) begin
      errors++;
      $display("FAIL mid_no_done got %0d want 0", nd);
    end
    capture(56, -1, -1);
    fd = -1;
    for (int k = 0; k < 56; k++)
      if (fd < 0 && c_done[k] === 1'b1) fd = k;
    checks++;
    if (fd != 52) begin
      errors++;
      $display("FAIL mid_rerun_done got %0d want 52", fd);
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    fft_start = 1'b0;
    for (int s = 0; s < NST; s++) map_dly[s] = 1;
    test_reset();
    test_nominal();
    test_banks();
    test_random_mapper();
    test_slow_mapper();
    test_timeout();
    test_start_busy();
    test_reset_mid_run();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
